// File: rtl/hazard_control_if.sv
// Signal bundle between the pipeline datapath and the hazard control unit.
// The datapath side (master) drives the hazard inputs and consumes the stall/flush controls.
interface hazard_control_if;
    logic       IdExMemRead;
    logic [4:0] IdExRt;
    logic [4:0] IfIdRs;
    logic [4:0] IfIdRt;
    logic       IfIdUsesRt;
    logic       BranchTaken;
    logic       MemBusy;

    logic        HazardSel;
    logic        PCWrite;
    logic        IfIdWrite;
    logic        IfIdFlush;
    logic        Freeze;
    logic [1:0]  State;
    logic [15:0] StallCount;

    modport master (
        output IdExMemRead, IdExRt, IfIdRs, IfIdRt, IfIdUsesRt, BranchTaken, MemBusy,
        input  HazardSel, PCWrite, IfIdWrite, IfIdFlush, Freeze, State, StallCount
    );

    modport slave (
        input  IdExMemRead, IdExRt, IfIdRs, IfIdRt, IfIdUsesRt, BranchTaken, MemBusy,
        output HazardSel, PCWrite, IfIdWrite, IfIdFlush, Freeze, State, StallCount
    );
endinterface

// File: rtl/hazard_control.sv
// Pipeline hazard unit: load-use stalls, taken-branch flushes and memory-wait freezes,
// with a saturating counter of cycles in which the PC was held.
module hazard_control #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BRANCH_PENALTY    = 1
) (
    input logic             clk,
    input logic             rst,
    hazard_control_if.slave bus
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } stateT;

    typedef enum logic [1:0] {
        ACT_RUN,
        ACT_STALL,
        ACT_FLUSH,
        ACT_HOLD
    } actionT;

    // Counter reload values are the cycles remaining after the one that starts the event.
    localparam logic [3:0] StallReload = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [3:0] FlushReload = 4'(BRANCH_PENALTY - 1);

    stateT       state;
    stateT       nextState;
    logic [3:0]  cnt;
    logic [3:0]  nextCnt;
    actionT      action;
    logic        loadUse;
    logic [15:0] stallCount;

    always_comb begin
        loadUse = bus.IdExMemRead && (bus.IdExRt != 5'd0) &&
                  ((bus.IdExRt == bus.IfIdRs) ||
                   (bus.IfIdUsesRt && (bus.IdExRt == bus.IfIdRt)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    // Memory wait outranks a branch, which outranks any load-use stall in progress.
    always_comb begin
        action    = ACT_RUN;
        nextState = state;
        nextCnt   = cnt;
        if (bus.MemBusy) begin
            action = ACT_HOLD;
        end else if (bus.BranchTaken) begin
            action    = ACT_FLUSH;
            nextCnt   = FlushReload;
            nextState = (FlushReload != 4'd0) ? FLUSH : RUN;
        end else begin
            case (state)
                RUN: begin
                    if (loadUse) begin
                        action    = ACT_STALL;
                        nextCnt   = StallReload;
                        nextState = (StallReload != 4'd0) ? LOAD_STALL : RUN;
                    end
                end
                LOAD_STALL: begin
                    action  = ACT_STALL;
                    nextCnt = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        nextState = RUN;
                    end
                end
                FLUSH: begin
                    action  = ACT_FLUSH;
                    nextCnt = cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        nextState = RUN;
                    end
                end
                default: begin
                    nextState = RUN;
                    nextCnt   = 4'd0;
                end
            endcase
        end
    end

    // Reset forces the free-running outputs immediately, without waiting for a clock.
    always_comb begin
        bus.HazardSel = 1'b0;
        bus.PCWrite   = 1'b1;
        bus.IfIdWrite = 1'b1;
        bus.IfIdFlush = 1'b0;
        bus.Freeze    = 1'b0;
        if (!rst) begin
            case (action)
                ACT_HOLD: begin
                    bus.PCWrite   = 1'b0;
                    bus.IfIdWrite = 1'b0;
                    bus.Freeze    = 1'b1;
                end
                ACT_FLUSH: begin
                    bus.HazardSel = 1'b1;
                    bus.IfIdFlush = 1'b1;
                end
                ACT_STALL: begin
                    bus.HazardSel = 1'b1;
                    bus.PCWrite   = 1'b0;
                    bus.IfIdWrite = 1'b0;
                end
                default: begin
                    bus.HazardSel = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount <= 16'd0;
        end else if (!bus.PCWrite && (stallCount != 16'hFFFF)) begin
            stallCount <= stallCount + 16'd1;
        end
    end

    assign bus.State      = state;
    assign bus.StallCount = stallCount;

endmodule

// File: tb/tb_hazard_control.sv
// Drives two hazard units (default and LOAD_STALL_CYCLES=3/BRANCH_PENALTY=2) with identical
// stimulus and compares both against a cycle-count model of stalls and flushes.
module tb_hazard_control;

    localparam int LscOf [2] = '{1, 3};
    localparam int BpOf  [2] = '{1, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       memRead = 1'b0;
    logic [4:0] exRt = 5'd0;
    logic [4:0] idRs = 5'd0;
    logic [4:0] idRt = 5'd0;
    logic       usesRt = 1'b0;
    logic       branch = 1'b0;
    logic       busy = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    int stallLeft [2];
    int flushLeft [2];
    int mCount    [2];

    hazard_control_if busA ();
    hazard_control_if busB ();

    assign busA.IdExMemRead = memRead;
    assign busA.IdExRt      = exRt;
    assign busA.IfIdRs      = idRs;
    assign busA.IfIdRt      = idRt;
    assign busA.IfIdUsesRt  = usesRt;
    assign busA.BranchTaken = branch;
    assign busA.MemBusy     = busy;
    assign busB.IdExMemRead = memRead;
    assign busB.IdExRt      = exRt;
    assign busB.IfIdRs      = idRs;
    assign busB.IfIdRt      = idRt;
    assign busB.IfIdUsesRt  = usesRt;
    assign busB.BranchTaken = branch;
    assign busB.MemBusy     = busy;

    hazard_control dutA (.clk(clk), .rst(rst), .bus(busA));
    hazard_control #(.LOAD_STALL_CYCLES(3), .BRANCH_PENALTY(2)) dutB (.clk(clk), .rst(rst), .bus(busB));

    always #5 clk = ~clk;

    function automatic logic [22:0] observe(int k);
        if (k == 0)
            return {busA.HazardSel, busA.PCWrite, busA.IfIdWrite, busA.IfIdFlush, busA.Freeze,
                    busA.State, busA.StallCount};
        return {busB.HazardSel, busB.PCWrite, busB.IfIdWrite, busB.IfIdFlush, busB.Freeze,
                busB.State, busB.StallCount};
    endfunction

    function automatic bit modelLoadUse();
        return memRead && exRt != 0 && (exRt == idRs || (usesRt && exRt == idRt));
    endfunction

    function automatic bit modelStalling(int k);
        return !rst && !busy && !branch && flushLeft[k] == 0 && (stallLeft[k] > 0 || modelLoadUse());
    endfunction

    // Expected outputs {HazardSel,PCWrite,IfIdWrite,IfIdFlush,Freeze,State,StallCount}.
    function automatic logic [22:0] expected(int k);
        logic hz = 1'b0, pcw = 1'b1, ifw = 1'b1, fl = 1'b0, fz = 1'b0;
        logic [1:0] st;
        if (!rst) begin
            if (busy) begin
                pcw = 1'b0; ifw = 1'b0; fz = 1'b1;
            end else if (branch || flushLeft[k] > 0) begin
                hz = 1'b1; fl = 1'b1;
            end else if (modelStalling(k)) begin
                hz = 1'b1; pcw = 1'b0; ifw = 1'b0;
            end
        end
        st = (flushLeft[k] > 0) ? 2'd2 : (stallLeft[k] > 0) ? 2'd1 : 2'd0;
        return {hz, pcw, ifw, fl, fz, st, 16'(mCount[k])};
    endfunction

    task automatic resetModels();
        for (int k = 0; k < 2; k++) begin
            stallLeft[k] = 0;
            flushLeft[k] = 0;
            mCount[k]    = 0;
        end
    endtask

    task automatic advanceModels();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                stallLeft[k] = 0; flushLeft[k] = 0; mCount[k] = 0;
            end else begin
                if ((busy || modelStalling(k)) && mCount[k] < 65535) mCount[k]++;
                if (busy) begin
                end else if (branch) begin
                    flushLeft[k] = BpOf[k] - 1;
                    stallLeft[k] = 0;
                end else if (flushLeft[k] > 0) begin
                    flushLeft[k]--;
                end else if (stallLeft[k] > 0) begin
                    stallLeft[k]--;
                end else if (modelLoadUse()) begin
                    stallLeft[k] = LscOf[k] - 1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                                 input logic [4:0] rtSrc, input logic ur, input logic br,
                                 input logic mb);
        memRead = mr; exRt = rt; idRs = rs; idRt = rtSrc; usesRt = ur; branch = br; busy = mb;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        advanceModels();
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        resetModels();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        resetModels();
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (observe(k) !== expected(k)) begin
                    miscompares++;
                    $display("FAIL reset dut%0d: got %h want %h", k, observe(k), expected(k));
                end
            end
            vectors++;
            if (busA.PCWrite !== 1'b1 || busA.HazardSel !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_outputs: PCWrite=%b HazardSel=%b want 1/0", busA.PCWrite, busA.HazardSel);
            end
            clockEdge();
        end
        rst = 1'b0;
    endtask

    task automatic test_single_stall();
        pulseReset();
        for (int c = 0; c < 4; c++) begin
            if (c == 0) applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
            else        applyStimulus(1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (observe(k) !== expected(k)) begin
                    miscompares++;
                    $display("FAIL single_stall c%0d dut%0d: got %h want %h", c, k, observe(k), expected(k));
                end
            end
            clockEdge();
        end
        vectors++;
        if (busA.StallCount !== 16'd1) begin
            miscompares++;
            $display("FAIL single_stall_count: got %0d want 1", busA.StallCount);
        end
        vectors++;
        if (busB.StallCount !== 16'd3) begin
            miscompares++;
            $display("FAIL three_cycle_stall_count: got %0d want 3", busB.StallCount);
        end
    endtask

    task automatic test_no_stall_cases();
        pulseReset();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
            else        applyStimulus(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (observe(k) !== expected(k) || observe(k)[21] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL no_stall c%0d dut%0d: got %h want %h", c, k, observe(k), expected(k));
                end
            end
            clockEdge();
        end
    endtask

    task automatic test_branch();
        pulseReset();
        // Branch with a load-use, idle, then a load-use interrupted by a branch.
        for (int c = 0; c < 8; c++) begin
            applyStimulus(c == 0 || c == 3, 5'd4, 5'd4, 5'd0, 1'b0, c == 0 || c == 4, 1'b0);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (observe(k) !== expected(k)) begin
                    miscompares++;
                    $display("FAIL branch c%0d dut%0d: got %h want %h", c, k, observe(k), expected(k));
                end
            end
            if (c == 1) begin
                vectors++;
                if (busB.IfIdFlush !== 1'b1 || busB.PCWrite !== 1'b1) begin
                    miscompares++;
                    $display("FAIL branch_penalty2: flush=%b pcw=%b want 1/1", busB.IfIdFlush, busB.PCWrite);
                end
            end
            clockEdge();
        end
        vectors++;
        if (busB.StallCount !== 16'd1) begin
            miscompares++;
            $display("FAIL branch_abort_count: got %0d want 1", busB.StallCount);
        end
    endtask

    task automatic test_memory_hold();
        pulseReset();
        for (int c = 0; c < 8; c++) begin
            applyStimulus(c == 0, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, c >= 1 && c <= 4);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (observe(k) !== expected(k)) begin
                    miscompares++;
                    $display("FAIL memory_hold c%0d dut%0d: got %h want %h", c, k, observe(k), expected(k));
                end
            end
            clockEdge();
        end
        vectors++;
        if (busB.StallCount !== 16'd7) begin
            miscompares++;
            $display("FAIL memory_hold_count: got %0d want 7", busB.StallCount);
        end
    endtask

    task automatic test_async_reset_flush();
        pulseReset();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (busB.State !== 2'd2) begin
            miscompares++;
            $display("FAIL enter_flush: State got %0d want 2", busB.State);
        end
        rst = 1'b1;
        resetModels();
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (observe(k) !== {5'b01100, 2'd0, 16'd0}) begin
                miscompares++;
                $display("FAIL async_reset dut%0d: got %h want %h", k, observe(k), {5'b01100, 18'd0});
            end
        end
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (observe(k) !== expected(k)) begin
                miscompares++;
                $display("FAIL after_reset dut%0d: got %h want %h", k, observe(k), expected(k));
            end
        end
        clockEdge();
    endtask

    task automatic test_random();
        pulseReset();
        for (int c = 0; c < 3000; c++) begin
            rst = 1'b0;
            applyStimulus($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) begin
                rst = 1'b1;
                resetModels();
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (observe(k) !== expected(k)) begin
                    miscompares++;
                    $display("FAIL random c%0d dut%0d: got %h want %h", c, k, observe(k), expected(k));
                end
            end
            clockEdge();
        end
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        pulseReset();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 65540; c++) clockEdge();
        applyStimulus(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (observe(k) !== expected(k) || observe(k)[15:0] !== 16'hFFFF) begin
                    miscompares++;
                    $display("FAIL saturation c%0d dut%0d: got %h want %h", c, k, observe(k), expected(k));
                end
            end
            clockEdge();
        end
    endtask

    initial begin
        resetModels();
        test_reset();
        test_single_stall();
        test_no_stall_cases();
        test_branch();
        test_memory_hold();
        test_async_reset_flush();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 Parameter: LOAD_STALL_CYCLES, default 1, range 1..15, ID-stage stall cycles per load-use hazard.
REQ-002 Parameter: BRANCH_PENALTY, default 1, range 1..15, IF/ID flush cycles per taken branch.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 IdExMemRead  in  1  instruction in ID/EX is a load.
REQ-006 IdExRt  in  5  load destination register in ID/EX.
REQ-007 IfIdRs  in  5  source register Rs of instruction in IF/ID.
REQ-008 IfIdRt  in  5  source register Rt of instruction in IF/ID.
REQ-009 IfIdUsesRt  in  1  IF/ID instruction reads Rt.
REQ-010 BranchTaken  in  1  branch resolved taken this cycle.
REQ-011 MemBusy  in  1  data memory not ready; whole pipeline must hold.
REQ-012 HazardSel  out  1  drives the bubble mux; 1 zeroes ID-stage control signals.
REQ-013 PCWrite  out  1  PC update enable.
REQ-014 IfIdWrite  out  1  IF/ID register write enable.
REQ-015 IfIdFlush  out  1  clears IF/ID register.
REQ-016 Freeze  out  1  holds ID/EX, EX/MEM, MEM/WB registers.
REQ-017 State  out  2  debug: RUN=0, LOAD_STALL=1, FLUSH=2.
REQ-018 StallCount  out  16  saturating count of cycles with PCWrite=0.

Function
REQ-019 load_use SHALL be defined as IdExMemRead && IdExRt!=0 && (IdExRt==IfIdRs || (IfIdUsesRt && IdExRt==IfIdRt)).
REQ-020 The unit SHALL hold a 2-bit state register and a 4-bit remaining-cycle counter cnt.
REQ-021 Priority SHALL be: MemBusy > BranchTaken > load_use or LOAD_STALL > idle.
REQ-022 MemBusy=1 in any state SHALL output Freeze=1, PCWrite=0, IfIdWrite=0, HazardSel=0, IfIdFlush=0, and SHALL hold state and cnt.
REQ-023 Flush action (BranchTaken=1, MemBusy=0, any state) SHALL output HazardSel=1, IfIdFlush=1, PCWrite=1, IfIdWrite=1, Freeze=0.
REQ-024 Flush action in RUN or LOAD_STALL SHALL load cnt=BRANCH_PENALTY-1 and go to FLUSH if nonzero, else RUN; a pending load stall SHALL be aborted.
REQ-025 In FLUSH without MemBusy, the outputs SHALL be the flush outputs; cnt SHALL decrement; when cnt==1 the next state SHALL be RUN. BranchTaken in FLUSH SHALL reload cnt per REQ-024.
REQ-026 Stall action (RUN, load_use=1, BranchTaken=0, MemBusy=0) SHALL output HazardSel=1, PCWrite=0, IfIdWrite=0, IfIdFlush=0, Freeze=0, all in the same cycle (combinational).
REQ-027 Stall action SHALL load cnt=LOAD_STALL_CYCLES-1 and go to LOAD_STALL if nonzero, else stay in RUN.
REQ-028 LOAD_STALL without BranchTaken or MemBusy SHALL output the stall outputs regardless of load_use, decrement cnt, and return to RUN when cnt==1.
REQ-029 RUN with no event SHALL output HazardSel=0, PCWrite=1, IfIdWrite=1, IfIdFlush=0, Freeze=0.
REQ-030 StallCount SHALL increment on each clock edge where PCWrite=0 and rst=0, and SHALL saturate at 16'hFFFF.
REQ-031 IdExRt==0 SHALL never cause a stall.

Reset
REQ-032 rst=1 SHALL immediately force state=RUN, cnt=0, StallCount=0, HazardSel=0, PCWrite=1, IfIdWrite=1, IfIdFlush=0, Freeze=0, regardless of the other inputs.
REQ-033 rst asserted mid-LOAD_STALL or mid-FLUSH SHALL abandon the operation; after release the unit SHALL start in RUN.

Verification
REQ-034 Defaults, IdExMemRead=1, IdExRt=5, IfIdRs=5 for 1 cycle -> HazardSel=1, PCWrite=0 that cycle only; StallCount=1.
REQ-035 LOAD_STALL_CYCLES=3, same hazard for 1 cycle, then IdExMemRead=0 -> stall outputs for exactly 3 cycles, State 0,1,1,0; StallCount=3.
REQ-036 IdExRt=0 with IfIdRs=0 and IdExMemRead=1 -> no stall; also IdExRt=7, IfIdRt=7, IfIdUsesRt=0 -> no stall.
REQ-037 BRANCH_PENALTY=2, BranchTaken=1 together with load_use -> IfIdFlush=1 and PCWrite=1 for 2 cycles, no stall; BranchTaken during LOAD_STALL aborts the stall.
REQ-038 LOAD_STALL_CYCLES=3, MemBusy=1 for 4 cycles during LOAD_STALL -> Freeze=1, HazardSel=0, cnt held; stall resumes afterwards; StallCount grows by 7 in total.
REQ-039 rst pulsed mid-FLUSH -> all outputs at reset values asynchronously; force StallCount to 16'hFFFF plus 1 stall -> it stays at FFFF.
